fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, giving prefetch FIFO entries; the legal values are powers of two from 2 to 8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port fetch_en, input, 1 bit: while high, the unit is allowed to fetch.
REQ-006 SHALL have port mem_addr, output, 32 bits (address_t): the byte address presented to instr_memory.
REQ-007 SHALL have port mem_data, input, 32 bits (word_t): the combinational read data from instr_memory for mem_addr, valid in the same cycle.
REQ-008 SHALL have port redirect_valid, input, 1 bit: a branch or jump redirect request.
REQ-009 SHALL have port redirect_pc, input, 32 bits: the redirect target.
REQ-010 SHALL have port instr_valid, output, 1 bit: the FIFO head holds an instruction.
REQ-011 SHALL have port instr_ready, input, 1 bit: the consumer accepts the head this cycle.
REQ-012 SHALL have port instr, output, 32 bits: the head instruction word.
REQ-013 SHALL have port instr_pc, output, 32 bits: the byte address of the head instruction.

Function
REQ-014 SHALL hold fetch_pc in a register, drive mem_addr = fetch_pc combinationally, and keep fetch_pc[1:0] at 0 at all times.
REQ-015 SHALL implement FSM states IDLE, FETCH and STALL:
- IDLE when fetch_en=0.
- FETCH when fetch_en=1 and a push is possible.
- STALL when fetch_en=1, the FIFO is full and there is no pop.
REQ-016 SHALL define pop as instr_valid && instr_ready, evaluated in the same cycle as the transfer.
REQ-017 SHALL push when fetch_en=1, redirect_valid=0, and the FIFO is either not full or popping in the same cycle; a push captures {fetch_pc, mem_data} and sets fetch_pc <= fetch_pc + 4.
REQ-018 SHALL wrap fetch_pc modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error flag.
REQ-019 SHALL, when no push occurs, keep fetch_pc unchanged and issue no FIFO write.
REQ-020 SHALL drive instr_valid, instr and instr_pc only from the FIFO head; there is no bypass, so the minimum latency from push edge to instr_valid is 1 cycle.
REQ-021 SHALL sustain one instruction per cycle in steady state when fetch_en=1 and instr_ready=1.
REQ-022 SHALL hold instr and instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-023 SHALL give redirect_valid priority over push; on a redirect edge:
- the FIFO empties (count becomes 0);
- fetch_pc <= {redirect_pc[31:2], 2'b00};
- no push occurs.
REQ-024 SHALL count a pop that coincides with a redirect cycle as a completed transfer; the flush discards the remaining entries only.
REQ-025 SHALL let the FIFO drain normally when fetch_en=0, with no new pushes; a redirect in IDLE still updates fetch_pc and flushes.
REQ-026 SHALL keep the occupancy counter in 0..DEPTH, with read and write pointers wrapping modulo DEPTH.
REQ-027 SHALL never push when full without a pop, and never pop when empty.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force:
- fetch_pc = RESET_PC;
- FIFO count = 0 and both pointers = 0;
- state = IDLE;
- instr_valid = 0.
REQ-029 SHALL force instr and instr_pc to 0 during reset.
REQ-030 SHALL, when rst_n is asserted mid-operation, discard all buffered entries immediately and not wait for a clock edge.
REQ-031 SHALL, on the first rising edge with rst_n=1 and fetch_en=1, push the word at RESET_PC.

Verification
REQ-032 SHALL cover reset then streaming: reset release with fetch_en=1, instr_ready=1, and memory words 0..3 = A0..A3 -> instr_valid rises 1 cycle after the first edge; instr_pc sequence 0,4,8,12 with instr A0..A3 on consecutive cycles.
REQ-033 SHALL cover back-pressure: instr_ready=0 for 5 cycles -> exactly DEPTH=2 entries buffered (pc 0,4); fetch_pc holds at 8; state is STALL; instr_pc=0 is stable; after ready rises, the order is 0,4,8 with no loss or duplicate.
REQ-034 SHALL cover redirect: redirect_valid=1 with redirect_pc=32'h0000_0043 while the FIFO holds 2 entries -> the next cycle has instr_valid=0 and mem_addr=32'h40; the following head is instr_pc=32'h40.
REQ-035 SHALL cover simultaneous full, push and pop: FIFO full with instr_ready=1 -> one pop and one push in the same edge; count stays 2; fetch_pc advances by 4.
REQ-036 SHALL cover wrap-around: redirect to 32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 SHALL cover mid-stream reset: rst_n pulsed low between edges while streaming -> instr_valid drops immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, redirect handling and a
// small prefetch FIFO presenting one instruction per cycle to the consumer.
package fetch_unit_pkg;
  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] address_t;
  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    address_t pc;
    word_t    word;
  } fetch_entry_t;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter address_t    RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     fetch_en,
  output address_t mem_addr,
  input  word_t    mem_data,
  input  logic     redirect_valid,
  input  address_t redirect_pc,
  output logic     instr_valid,
  input  logic     instr_ready,
  output word_t    instr,
  output address_t instr_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam address_t    PC_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  address_t            fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  fetch_entry_t        fifo_q [DEPTH];

  logic                full_c;
  logic                pop_c;
  logic                push_c;
  logic                stall_c;

  // Handshake and push qualification; a redirect always wins over a push.
  always_comb begin
    full_c  = (cnt_q == CNT_W'(DEPTH));
    pop_c   = (cnt_q != '0) && instr_ready;
    push_c  = fetch_en && !redirect_valid && (!full_c || pop_c);
    stall_c = fetch_en && full_c && !pop_c;
  end

  // Fetch mode FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d = stall_c ? STALL : FETCH;
        end
      end
      FETCH: begin
        if (!fetch_en) begin
          state_d = IDLE;
        end else if (stall_c) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (!fetch_en) begin
          state_d = IDLE;
        end else if (!stall_c) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PC, pointer and occupancy next-state; a flush resets the pointers too.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & PC_MASK;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
    end else begin
      if (push_c) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC & PC_MASK;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Entry storage needs no reset: the head is only exposed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wr_ptr_q] <= '{pc: fetch_pc_q, word: mem_data};
    end
  end

  assign mem_addr    = fetch_pc_q;
  assign instr_valid = (cnt_q != '0);
  assign instr       = instr_valid ? fifo_q[rd_ptr_q].word : '0;
  assign instr_pc    = instr_valid ? fifo_q[rd_ptr_q].pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle model feeds a scoreboard queue
// of expected head entries that is compared against the DUT every cycle.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ST_IDLE  = 0;
  localparam int          ST_FETCH = 1;
  localparam int          ST_STALL = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          n_checks;
  int          n_errors;
  ent_t        sbq [$];
  logic [31:0] mpc;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  assign mem_data = word_of(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare outputs against the model, drive one cycle of stimulus, advance model.
  task automatic cycle(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic do_pop;
    logic do_push;
    check("instr_valid", 32'(instr_valid), 32'(sbq.size() != 0));
    check("mem_addr", mem_addr, mpc);
    if (sbq.size() != 0) begin
      check("instr_pc", instr_pc, sbq[0].pc);
      check("instr", instr, sbq[0].w);
    end
    fetch_en       = fe;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    do_pop  = (sbq.size() != 0) && rdy;
    do_push = fe && !rv && ((sbq.size() < int'(DEPTH)) || do_pop);
    @(posedge clk);
    if (do_pop) void'(sbq.pop_front());
    if (rv) begin
      sbq.delete();
      mpc = rpc & 32'hFFFF_FFFC;
    end else if (do_push) begin
      sbq.push_back('{mpc, word_of(mpc)});
      mpc = mpc + 32'd4;
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mpc            = RESET_PC;

    // Reset state.
    #12;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_mem_addr", mem_addr, RESET_PC);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming from reset: 0,4,8,12,... one per cycle.
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("stream_state", 32'(dut.state_q), 32'(ST_FETCH));

    // Mid-stream asynchronous reset between edges.
    #1 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(instr_valid), 32'd0);
    check("mrst_instr", instr, 32'd0);
    check("mrst_mem_addr", mem_addr, RESET_PC);
    #1 rst_n = 1'b1;
    sbq.delete();
    mpc = RESET_PC;

    // Back-pressure: fill to DEPTH and stall.
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("bp_state", 32'(dut.state_q), 32'(ST_STALL));
    check("bp_fetch_pc", mem_addr, 32'h8);
    check("bp_head_pc", instr_pc, 32'h0);
    check("bp_count", 32'(dut.cnt_q), 32'd2);

    // Full with simultaneous pop and push.
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("fpp_count", 32'(dut.cnt_q), 32'd2);
    check("fpp_fetch_pc", mem_addr, 32'hC);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while two entries are buffered.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0043);
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_mem_addr", mem_addr, 32'h40);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect coinciding with a pop.
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap-around.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Drain with fetch disabled, then redirect while idle.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0202);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0), $urandom);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
